// File: rtl/prescale_bank_pkg.sv
// Shared types for the prescaler bank: channel state encoding and mode encodings.
package prescale_bank_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } chan_state_e;

    localparam logic [1:0] MODE_TOGGLE  = 2'b00;
    localparam logic [1:0] MODE_PULSE   = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

endpackage

// File: rtl/prescale_chan.sv
// One prescaler channel: counts 1..R and fires an event at terminal count as a
// toggled clock, a repeating tick or a single tick, with shadowed ratio reloads.
module prescale_chan
    import prescale_bank_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] div,
    input  logic             load,
    output logic             wclk,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [1:0]       mode_q, mode_d;
    logic             wclk_q, wclk_d;
    logic             tick_q, tick_d;
    logic             tc;

    // Count never passes the ratio, so R of 0 or 1 gives a terminal count every cycle.
    assign tc = !(cnt_q < ratio_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ratio_d  = ratio_q;
        shadow_d = shadow_q;
        mode_d   = mode_q;
        wclk_d   = wclk_q;
        tick_d   = 1'b0;

        if (load) shadow_d = div;

        unique case (state_q)
            StIdle: begin
                cnt_d  = CNT_W'(1);
                wclk_d = 1'b0;
                if (load) ratio_d = div;
                if (en) begin
                    mode_d  = mode;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!en) begin
                    state_d = StIdle;
                    cnt_d   = CNT_W'(1);
                    wclk_d  = 1'b0;
                end else if (tc) begin
                    cnt_d = CNT_W'(1);
                    // Ratio only moves at a period boundary; a coincident load wins.
                    ratio_d = load ? div : shadow_q;
                    case (mode_q)
                        MODE_TOGGLE:  wclk_d = ~wclk_q;
                        MODE_ONESHOT: begin
                            tick_d  = 1'b1;
                            state_d = StDone;
                        end
                        default:      tick_d = 1'b1;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                if (load) ratio_d = div;
                if (!en) begin
                    state_d = StIdle;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= CNT_W'(1);
            ratio_q  <= CNT_W'(DEFAULT_DIV);
            shadow_q <= CNT_W'(DEFAULT_DIV);
            mode_q   <= MODE_TOGGLE;
            wclk_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ratio_q  <= ratio_d;
            shadow_q <= shadow_d;
            mode_q   <= mode_d;
            wclk_q   <= wclk_d;
            tick_q   <= tick_d;
        end
    end

    assign wclk = wclk_q;
    assign tick = tick_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: rtl/prescale_bank.sv
// Bank of NCH independent prescaler channels sharing one clock and reset.
module prescale_bank
    import prescale_bank_pkg::*;
#(
    parameter int unsigned NCH         = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       en,
    input  logic [2*NCH-1:0]     mode,
    input  logic [NCH*CNT_W-1:0] div,
    input  logic [NCH-1:0]       load,
    output logic [NCH-1:0]       wclk,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        prescale_chan #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en[i]),
            .mode (mode[2*i +: 2]),
            .div  (div[i*CNT_W +: CNT_W]),
            .load (load[i]),
            .wclk (wclk[i]),
            .tick (tick[i]),
            .busy (busy[i]),
            .done (done[i])
        );
    end

endmodule

// File: tb/tb_prescale_bank.sv
// Scoreboard bench: expected event cycles are queued when a channel is armed and
// matched against wclk edges / tick pulses seen by a negedge monitor.
module tb_prescale_bank;
    import prescale_bank_pkg::*;

    localparam int NCH   = 2;
    localparam int CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH-1:0]       en;
    logic [2*NCH-1:0]     mode;
    logic [NCH*CNT_W-1:0] div;
    logic [NCH-1:0]       load;
    logic [NCH-1:0]       wclk, tick, busy, done;

    prescale_bank #(
        .NCH        (NCH),
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .mode (mode),
        .div  (div),
        .load (load),
        .wclk (wclk),
        .tick (tick),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int q0[$];
    int q1[$];
    logic [NCH-1:0] mon_on = '0;
    logic [NCH-1:0] wprev  = '0;
    int last_evt;
    int start_cyc;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int ch, input int v);
        if (ch == 0) q0.push_back(v);
        else q1.push_back(v);
    endtask

    // Event code = cycle*2 + kind, kind 0 = wclk edge, 1 = tick.
    task automatic sb_pop(input int ch, input int obs);
        int exp;
        if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
            check($sformatf("unexpected_evt_ch%0d", ch), obs, -1);
        end else begin
            exp = (ch == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("evt_ch%0d", ch), obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (mon_on[ch] && wclk[ch] !== wprev[ch]) sb_pop(ch, cyc * 2);
                if (mon_on[ch] && tick[ch] === 1'b1) sb_pop(ch, cyc * 2 + 1);
            end
        end
        wprev = wclk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic prep(input int ch, input int r);
        div[ch*CNT_W +: CNT_W] = r[CNT_W-1:0];
        load[ch] = 1'b1;
    endtask

    task automatic arm(input int ch, input logic [1:0] md, input int r, input int n);
        int reff;
        int c0;
        mode[ch*2 +: 2] = md;
        en[ch]     = 1'b1;
        mon_on[ch] = 1'b1;
        c0   = cyc;
        reff = (r < 2) ? 1 : r;
        for (int k = 1; k <= n; k++)
            push(ch, (c0 + 1 + k * reff) * 2 + ((md == MODE_TOGGLE) ? 0 : 1));
        last_evt  = c0 + 1 + n * reff;
        start_cyc = c0;
    endtask

    task automatic stop(input int ch);
        mon_on[ch] = 1'b0;
        en[ch]     = 1'b0;
        step();
        step();
        check($sformatf("idle_busy_ch%0d", ch), int'(busy[ch]), 0);
        check($sformatf("idle_wclk_ch%0d", ch), int'(wclk[ch]), 0);
        check($sformatf("left_ch%0d", ch), (ch == 0) ? q0.size() : q1.size(), 0);
        if (ch == 0) q0.delete();
        else q1.delete();
    endtask

    initial begin
        int c0;
        rst_n = 1'b0;
        en    = '0;
        mode  = '0;
        div   = '0;
        load  = '0;
        step();
        step();
        check("rst_wclk", int'(wclk), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_busy", int'(busy), 0);

        // Toggle R=3; a mode change mid-run must be ignored.
        prep(0, 3);
        step();
        load = '0;
        arm(0, MODE_TOGGLE, 3, 5);
        step();
        step();
        mode[1:0] = MODE_PULSE;
        check("tog_busy", int'(busy[0]), 1);
        wait_cyc(last_evt + 1);
        stop(0);

        // Pulse with R=0 then R=1: a tick every RUN cycle.
        prep(1, 0);
        step();
        load = '0;
        arm(1, MODE_PULSE, 0, 4);
        wait_cyc(last_evt + 1);
        stop(1);
        prep(1, 1);
        step();
        load = '0;
        arm(1, MODE_PULSE, 1, 4);
        wait_cyc(last_evt + 1);
        stop(1);

        // One-shot R=4, then re-arm with the retained ratio.
        prep(0, 4);
        step();
        load = '0;
        arm(0, MODE_ONESHOT, 4, 1);
        wait_cyc(last_evt + 1);
        check("os_done", int'(done[0]), 1);
        check("os_busy", int'(busy[0]), 0);
        wait_cyc(cyc + 5);
        check("os_hold_tick", int'(tick[0]), 0);
        check("os_hold_done", int'(done[0]), 1);
        en[0] = 1'b0;
        step();
        step();
        check("os_clr_done", int'(done[0]), 0);
        arm(0, MODE_ONESHOT, 4, 1);
        wait_cyc(last_evt + 1);
        check("os2_done", int'(done[0]), 1);
        stop(0);

        // Shadow ratio: pulse R=5, load 2 mid-period, then load 3 on a TC.
        prep(1, 5);
        step();
        load = '0;
        arm(1, MODE_PULSE, 5, 0);
        c0 = start_cyc;
        push(1, (c0 + 6) * 2 + 1);
        push(1, (c0 + 8) * 2 + 1);
        push(1, (c0 + 10) * 2 + 1);
        push(1, (c0 + 12) * 2 + 1);
        push(1, (c0 + 15) * 2 + 1);
        push(1, (c0 + 18) * 2 + 1);
        wait_cyc(c0 + 2);
        prep(1, 2);
        wait_cyc(c0 + 3);
        load = '0;
        wait_cyc(c0 + 11);
        prep(1, 3);
        wait_cyc(c0 + 12);
        load = '0;
        wait_cyc(c0 + 19);
        stop(1);

        // Reset mid-run at C=3, R=7: outputs drop at once, ratios return to default.
        prep(0, 7);
        step();
        load = '0;
        arm(0, MODE_PULSE, 7, 0);
        c0 = start_cyc;
        wait_cyc(c0 + 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_tick", int'(tick), 0);
        check("abort_wclk", int'(wclk), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        en[0]     = 1'b0;
        mon_on[0] = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        arm(0, MODE_PULSE, 1, 3);
        wait_cyc(last_evt + 1);
        stop(0);

        // en drop mid-run: back to IDLE next cycle, ratio 7 kept.
        prep(0, 7);
        step();
        load = '0;
        arm(0, MODE_PULSE, 7, 0);
        c0 = start_cyc;
        wait_cyc(c0 + 3);
        en[0] = 1'b0;
        wait_cyc(c0 + 4);
        check("endrop_busy", int'(busy[0]), 0);
        check("endrop_tick", int'(tick[0]), 0);
        arm(0, MODE_PULSE, 7, 2);
        wait_cyc(last_evt + 1);
        stop(0);

        // Independence: ch0 toggle R=2, ch1 pulse R=3, load on ch1 only.
        prep(0, 2);
        prep(1, 3);
        step();
        load = '0;
        arm(0, MODE_TOGGLE, 2, 6);
        arm(1, MODE_PULSE, 3, 4);
        c0 = start_cyc;
        wait_cyc(c0 + 4);
        div[7:0] = 8'd7;
        prep(1, 3);
        step();
        load = '0;
        wait_cyc(c0 + 14);
        check("ind_busy", int'(busy), 3);
        stop(0);
        stop(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
